mine_place_ctrl: RTL and testbench
==================================

Name: mine_place_ctrl

Overview:
Sequencer that fills a 5x5 Minesweeper board with a requested number of unique mines.
Drives an LCG step, X[n+1] = (a*X[n] + c) mod 25, and rejects duplicate cells and the player's first-click (safe) cell.
Sits between the game FSM (start, first click) and the board/display logic, which consume out_mines.
Retries bounded; reports done or fail.

Parameters:
CELLS, 25, board cells (5x5); index width 5
MAX_TRIES, 64, rejected candidates allowed per run before fail
TRY_W, 7, width of reject counter (holds 0..MAX_TRIES)

Ports:
in_clka  in  1  clock, rising edge
in_reset  in  1  asynchronous reset, active-high
in_start  in  1  pulse: begin placement; sampled in IDLE/DONE/FAIL only
in_seed  in  5  X[0], captured on start
in_mult  in  5  LCG multiplier a, captured on start
in_increment  in  5  LCG increment c, captured on start
in_mines_num  in  5  mines to place, captured on start
in_safe_idx  in  5  first-click cell, never mined, captured on start
out_busy  out  1  high in LOAD/GEN/CHECK
out_done  out  1  level, high in DONE
out_fail  out  1  level, high in FAIL
out_mines  out  25  one bit per cell, bit i = row i/5, col i%5
out_placed_cnt  out  5  mines placed so far
out_reject_cnt  out  TRY_W  rejected candidates this run

Behaviour:
- Reset (any time, incl. mid-run): state IDLE; all outputs 0; captured operands 0.
- States: IDLE, LOAD, GEN, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + in_start=1 -> LOAD. Capture operands, clear out_mines, placed and reject counts, x <= in_seed. in_start while busy is ignored.
- LOAD:
  - in_mines_num > CELLS-1 (24) or in_safe_idx >= CELLS -> FAIL.
  - in_mines_num == 0 -> DONE.
  - else -> GEN.
- GEN: cand <= (a*x + c) mod 25. Full 10-bit product + 5-bit add (11 bits) before modulo; no truncation before mod. -> CHECK.
- CHECK:
  - Reject if cand == safe_idx or out_mines[cand] == 1. reject_cnt++; x <= cand. If reject_cnt+1 == MAX_TRIES -> FAIL, else -> GEN.
  - Accept otherwise. out_mines[cand] <= 1; placed++; x <= cand. If placed+1 == mines_num -> DONE, else -> GEN.
- Latency: 2 cycles per candidate. With K candidates evaluated (accepted + rejected), out_done rises 2K+2 rising edges after the edge that samples in_start.
- out_mines holds its value in DONE and FAIL until the next start or reset. In FAIL it is a partial board.
- Simultaneous in_start and in_reset: reset wins.
- Never writes bit in_safe_idx. Never exceeds mines_num bits set.

Optional Feature:
MINE_PLACE_LINEAR_PROBE_EN
- Defined: a rejected cand is not re-rolled. CHECK reloads cand <= (cand+1) mod 25 and stays in CHECK (1 cycle per probe); reject_cnt still increments. Termination is guaranteed since mines_num <= 24; FAIL occurs only via the LOAD checks. MAX_TRIES check is disabled.
- Undefined: re-roll via GEN with the MAX_TRIES bound, as above.

Decomposition:
- Package mine_pkg: CELLS, ROWS=5, COLS=5, IDX_W=5, cell index type, state enum.
- One combinational sub-module lcg_step (a, c, x -> (a*x+c) mod 25), reused by later board-shuffle logic.

Test Plan:
- seed=0, a=1, c=7, mines=3, safe=12 -> cells 7,14,21; out_mines=25'h0204080; done 8 edges after start; reject_cnt=0.
- seed=0, a=1, c=5, mines=2, safe=5 -> cand 5 rejected, then 10,15; out_mines=25'h0008400; reject_cnt=1; done 8 edges after start.
- seed=3, a=1, c=0, mines=2, safe=0:
  - Without macro: 3 placed, then 64 rejects of 3 -> out_fail=1, placed=1.
  - With MINE_PLACE_LINEAR_PROBE_EN: cells 3,4; out_mines=25'h0000018.
- mines=25 -> FAIL 2 edges after start, out_mines=0. mines=0 -> DONE, out_mines=0.
- in_reset asserted mid-run after 1 placement -> all outputs 0 immediately (async). Start reissued after release -> clean full run.
- in_start pulsed during GEN -> ignored; in_start in DONE -> new run clears out_mines before placing.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared types and constants for 5x5 mine placement.
package mine_pkg;

  localparam int unsigned CELLS     = 25;
  localparam int unsigned ROWS      = 5;
  localparam int unsigned COLS      = 5;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned MAX_TRIES = 64;
  localparam int unsigned TRY_W     = 7;
  localparam int unsigned SUM_W     = 11;

  typedef logic [IDX_W-1:0] cell_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/mine_place_ctrl_lcg_step.sv
// One LCG step: (a*x + c) mod 25, computed at full 11-bit width before the modulo.
module lcg_step
  import mine_pkg::*;
(
  input  logic [IDX_W-1:0] a,
  input  logic [IDX_W-1:0] c,
  input  logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] x_next_c
);

  logic [SUM_W-1:0] sum_c;

  // Product and add never overflow 11 bits (31*31+31 = 992)
  assign sum_c    = SUM_W'(a) * SUM_W'(x) + SUM_W'(c);
  assign x_next_c = IDX_W'(sum_c % SUM_W'(CELLS));

endmodule

// File: rtl/mine_place_ctrl.sv
// Places a requested number of unique mines on a 5x5 board using an LCG,
// skipping duplicates and the first-click safe cell.
// Build option: MINE_PLACE_LINEAR_PROBE_EN - resolve collisions by probing the
// next cell instead of re-rolling (no MAX_TRIES bound).
module mine_place_ctrl
  import mine_pkg::*;
(
  input  logic                 in_clka,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [IDX_W-1:0]     in_seed,
  input  logic [IDX_W-1:0]     in_mult,
  input  logic [IDX_W-1:0]     in_increment,
  input  logic [IDX_W-1:0]     in_mines_num,
  input  logic [IDX_W-1:0]     in_safe_idx,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_fail,
  output logic [CELLS-1:0]     out_mines,
  output logic [IDX_W-1:0]     out_placed_cnt,
  output logic [TRY_W-1:0]     out_reject_cnt
);

  state_t           state, state_next;
  cell_idx_t        x, x_next;
  cell_idx_t        cand, cand_next;
  cell_idx_t        mult, mult_next;
  cell_idx_t        incr, incr_next;
  cell_idx_t        mines_num, mines_num_next;
  cell_idx_t        safe_idx, safe_idx_next;
  logic [CELLS-1:0] mines_next;
  cell_idx_t        placed_next;
  logic [TRY_W-1:0] reject_next;
  cell_idx_t        lcg_c;
  logic             hit_c;

  lcg_step u_lcg_step (
    .a        (mult),
    .c        (incr),
    .x        (x),
    .x_next_c (lcg_c)
  );

  assign hit_c = (cand == safe_idx) || out_mines[cand];

  // Next-state and datapath update
  always_comb begin
    state_next     = state;
    x_next         = x;
    cand_next      = cand;
    mult_next      = mult;
    incr_next      = incr;
    mines_num_next = mines_num;
    safe_idx_next  = safe_idx;
    mines_next     = out_mines;
    placed_next    = out_placed_cnt;
    reject_next    = out_reject_cnt;

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (in_start) begin
          state_next     = ST_LOAD;
          mult_next      = in_mult;
          incr_next      = in_increment;
          mines_num_next = in_mines_num;
          safe_idx_next  = in_safe_idx;
          x_next         = in_seed;
          mines_next     = '0;
          placed_next    = '0;
          reject_next    = '0;
        end
      end
      ST_LOAD: begin
        if ((mines_num > IDX_W'(CELLS - 1)) || (safe_idx >= IDX_W'(CELLS)))
          state_next = ST_FAIL;
        else if (mines_num == '0)
          state_next = ST_DONE;
        else
          state_next = ST_GEN;
      end
      ST_GEN: begin
        cand_next  = lcg_c;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (hit_c) begin
          x_next = cand;
`ifdef MINE_PLACE_LINEAR_PROBE_EN
          // Probe forward; the counter saturates since probing is unbounded by design
          if (out_reject_cnt != {TRY_W{1'b1}})
            reject_next = out_reject_cnt + TRY_W'(1);
          cand_next = (cand == IDX_W'(CELLS - 1)) ? '0 : cand + IDX_W'(1);
`else
          reject_next = out_reject_cnt + TRY_W'(1);
          if (out_reject_cnt == TRY_W'(MAX_TRIES - 1))
            state_next = ST_FAIL;
          else
            state_next = ST_GEN;
`endif
        end else begin
          mines_next[cand] = 1'b1;
          placed_next      = out_placed_cnt + IDX_W'(1);
          x_next           = cand;
          if (out_placed_cnt == mines_num - IDX_W'(1))
            state_next = ST_DONE;
          else
            state_next = ST_GEN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and status registers
  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      state          <= ST_IDLE;
      x              <= '0;
      cand           <= '0;
      mult           <= '0;
      incr           <= '0;
      mines_num      <= '0;
      safe_idx       <= '0;
      out_mines      <= '0;
      out_placed_cnt <= '0;
      out_reject_cnt <= '0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_fail       <= 1'b0;
    end else begin
      state          <= state_next;
      x              <= x_next;
      cand           <= cand_next;
      mult           <= mult_next;
      incr           <= incr_next;
      mines_num      <= mines_num_next;
      safe_idx       <= safe_idx_next;
      out_mines      <= mines_next;
      out_placed_cnt <= placed_next;
      out_reject_cnt <= reject_next;
      out_busy       <= (state == ST_LOAD) || (state == ST_GEN) || (state == ST_CHECK);
      out_done       <= (state == ST_DONE);
      out_fail       <= (state == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Scoreboard bench for mine_place_ctrl: driver pushes model results, monitor
// pops and compares whenever done or fail rises.
module tb_mine_place_ctrl;

  logic        in_clka = 1'b0;
  logic        in_reset;
  logic        in_start;
  logic [4:0]  in_seed, in_mult, in_increment, in_mines_num, in_safe_idx;
  logic        out_busy, out_done, out_fail;
  logic [24:0] out_mines;
  logic [4:0]  out_placed_cnt;
  logic [6:0]  out_reject_cnt;

  mine_place_ctrl dut (
    .in_clka        (in_clka),
    .in_reset       (in_reset),
    .in_start       (in_start),
    .in_seed        (in_seed),
    .in_mult        (in_mult),
    .in_increment   (in_increment),
    .in_mines_num   (in_mines_num),
    .in_safe_idx    (in_safe_idx),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .out_fail       (out_fail),
    .out_mines      (out_mines),
    .out_placed_cnt (out_placed_cnt),
    .out_reject_cnt (out_reject_cnt)
  );

  always #5 in_clka = ~in_clka;

  typedef struct {
    logic [24:0] mines;
    int          placed;
    int          rej;
    bit          fail;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   prev_done = 0, prev_fail = 0;

  always @(posedge in_clka) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: play out the placement rules directly on a board array
  function automatic exp_t model(int seed, int a, int c, int n, int safe);
    exp_t  e;
    bit    board[25];
    int    x, cand, gens, probes;
    e.mines = '0; e.placed = 0; e.rej = 0; e.fail = 0; e.lat = 2; e.start_cyc = 0;
    for (int i = 0; i < 25; i++) board[i] = 0;
    if (n > 24 || safe >= 25) begin
      e.fail = 1;
      return e;
    end
    if (n == 0) return e;
    x = seed; gens = 0; probes = 0;
    while (e.placed < n) begin
      cand = (a * x + c) % 25;
      gens++;
`ifdef MINE_PLACE_LINEAR_PROBE_EN
      while (cand == safe || board[cand]) begin
        if (e.rej < 127) e.rej++;
        cand = (cand + 1) % 25;
        probes++;
      end
      board[cand] = 1; e.placed++; x = cand;
`else
      if (cand == safe || board[cand]) begin
        e.rej++; x = cand;
        if (e.rej == 64) begin
          e.fail = 1;
          break;
        end
      end else begin
        board[cand] = 1; e.placed++; x = cand;
      end
`endif
    end
    for (int i = 0; i < 25; i++) e.mines[i] = board[i];
    e.lat = 2 + 2 * gens + probes;
    return e;
  endfunction

  // Monitor: compare on each rising done/fail
  always @(negedge in_clka) begin
    exp_t e;
    if (in_reset) begin
      prev_done = 0; prev_fail = 0;
    end else begin
      if ((out_done && !prev_done) || (out_fail && !prev_fail)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done",    out_done, !e.fail);
          chk("fail",    out_fail, e.fail);
          chk("mines",   out_mines, e.mines);
          chk("placed",  out_placed_cnt, e.placed);
          chk("rejects", out_reject_cnt, e.rej);
          chk("latency", cyc - e.start_cyc, e.lat);
          chk("busy_at_end", out_busy, 0);
        end
      end
      prev_done = out_done; prev_fail = out_fail;
    end
  end

  task automatic start_run(input int seed, input int a, input int c, input int n,
                           input int safe, input bit glitch);
    exp_t e;
    @(negedge in_clka);
    in_seed = 5'(seed); in_mult = 5'(a); in_increment = 5'(c);
    in_mines_num = 5'(n); in_safe_idx = 5'(safe);
    in_start = 1'b1;
    @(posedge in_clka);
    #1;
    e = model(seed, a, c, n, safe);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge in_clka);
    in_start = 1'b0;
    // Scramble inputs: operands must already be captured
    in_seed = 5'($urandom); in_mult = 5'($urandom); in_increment = 5'($urandom);
    in_mines_num = 5'($urandom); in_safe_idx = 5'($urandom);
    @(posedge in_clka);
    #1;
    chk("busy_after_start", out_busy, 1);
    if (glitch) begin
      @(negedge in_clka);
      in_start = 1'b1;
      @(negedge in_clka);
      in_start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 800 && exp_q.size() > 0; i++) @(posedge in_clka);
    #2;
    if (exp_q.size() > 0) begin
      chk("completion_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic run(input int seed, input int a, input int c, input int n,
                     input int safe, input bit glitch);
    start_run(seed, a, c, n, safe, glitch);
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   out_busy, 0);
    chk({tag, "_done"},   out_done, 0);
    chk({tag, "_fail"},   out_fail, 0);
    chk({tag, "_mines"},  out_mines, 0);
    chk({tag, "_placed"}, out_placed_cnt, 0);
    chk({tag, "_rej"},    out_reject_cnt, 0);
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b0;
    in_seed = '0; in_mult = '0; in_increment = '0; in_mines_num = '0; in_safe_idx = '0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge in_clka);
    @(negedge in_clka);
    in_reset = 1'b0;

    // Directed cases
    run(0, 1, 7, 3, 12, 0);
    run(0, 1, 5, 2, 5, 0);
    run(3, 1, 0, 2, 0, 0);
    run(9, 2, 3, 25, 4, 0);
    run(9, 2, 3, 0, 4, 0);
    run(1, 1, 1, 5, 30, 0);
    run(0, 1, 7, 3, 12, 1);
    run(0, 1, 7, 3, 12, 0);

    // Asynchronous reset after the first placement
    start_run(0, 1, 7, 3, 12, 0);
    for (int i = 0; i < 50 && out_placed_cnt != 5'd1; i++) @(negedge in_clka);
    chk("placed_before_reset", out_placed_cnt, 1);
    #2;
    in_reset = 1'b1;
    #1;
    check_zero("midrun_reset");
    exp_q.delete();
    repeat (2) @(posedge in_clka);
    @(negedge in_clka);
    in_reset = 1'b0;
    run(0, 1, 7, 3, 12, 0);

    // Randomized runs
    for (int i = 0; i < 40; i++) begin
      int s, a, c, n, sf;
      s  = $urandom_range(0, 31);
      a  = $urandom_range(0, 31);
      c  = $urandom_range(0, 31);
      n  = $urandom_range(0, 25);
      sf = ($urandom_range(0, 9) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24);
      run(s, a, c, n, sf, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
